param_fifo_flags: RTL and testbench
===================================

PARAM_FIFO_FLAGS -- requirements
Module: param_fifo_flags

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, meaning data word width in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 8, meaning pointer width; DEPTH = 2**ADDR_W entries (default 256).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 wr_en  input  1  write request.
REQ-007 wr_data  input  DATA_W  write word.
REQ-008 rd_en  input  1  read request.
REQ-009 rd_data  output  DATA_W  read word, registered.
REQ-010 rd_valid  output  1  pulses high one cycle when rd_data carries an accepted read.
REQ-011 ae_thresh  input  ADDR_W+1  almost-empty threshold (occupancy).
REQ-012 af_thresh  input  ADDR_W+1  almost-full threshold (occupancy).
REQ-013 err_clr  input  1  clears sticky error flags.
REQ-014 count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-015 full, empty, almost_full, almost_empty, half_flag  output  1 each  registered status flags.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Write accepted when wr_en && (!full || read accepted same cycle); data stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-018 Read accepted when rd_en && !empty; rd_data updated next edge from rd_ptr, rd_ptr increments modulo DEPTH, rd_valid high that following cycle only.
REQ-019 Read latency SHALL be exactly 1 cycle; rd_data SHALL hold its last value when no read is accepted.
REQ-020 count SHALL increment on write-only, decrement on read-only, hold on both or neither.
REQ-021 Flags SHALL be registered from next-count so they change on the same edge as count: empty = (count==0), full = (count==DEPTH), half_flag = (count>=DEPTH/2), almost_empty = (count<=ae_thresh), almost_full = (count>=af_thresh).
REQ-022 Simultaneous rd_en/wr_en when full: both accepted, count stays DEPTH, full stays 1.
REQ-023 Simultaneous rd_en/wr_en when empty: write accepted, read rejected, underflow set, count becomes 1.
REQ-024 wr_en while full without accepted read: write dropped, memory/pointers unchanged, overflow set.
REQ-025 rd_en while empty: read dropped, rd_valid stays 0, underflow set.
REQ-026 overflow/underflow SHALL stay set until err_clr; if err_clr coincides with a new error the flag SHALL remain set.
REQ-027 Threshold inputs SHALL be sampled every cycle; a change takes effect on flags at the next edge.

Reset
REQ-028 On rst_n low: pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, half_flag 0, overflow 0, underflow 0, rd_valid 0, rd_data 0; memory contents not reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored data and pending reads immediately; first accepted write after release stores at address 0.

Structure
REQ-030 Shared package fifo_pkg SHALL hold default DATA_W/ADDR_W constants and a status-flag struct/typedef (full, empty, almost_full, almost_empty, half_flag).
REQ-031 Flag generation SHALL be a sub-module fifo_flag_gen (next count + thresholds in, registered flags out); storage and pointers remain in param_fifo_flags.

Verification
REQ-032 Reset then idle -> count 0, empty 1, almost_empty 1, all others 0.
REQ-033 Defaults, ae_thresh 8, af_thresh 248; write 256 words 0..255 -> almost_empty clears at count 9, half_flag sets at 128, almost_full sets at 248, full at 256.
REQ-034 Full FIFO, extra wr_en -> overflow 1, count 256; err_clr -> overflow 0; read all 256 -> rd_data 0..255 in order, each one cycle after rd_en, empty at end.
REQ-035 Empty FIFO, rd_en and wr_en same cycle with data 0xA5 -> underflow 1, count 1; next read returns 0xA5.
REQ-036 Wrap: write/read 300 words streaming with count held at 4 -> data order preserved across pointer wrap, no error flags.
REQ-037 Reset asserted with count 100 -> all flags to reset values same cycle; post-release write/read of 0x3C returns 0x3C.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the parameterised FIFO with status flags.
// Contents:
//   DEF_DATA_W / DEF_ADDR_W : default word width and pointer width
//   fifo_flags_t            : registered status flag bundle
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic half_flag;
  } fifo_flags_t;

  // Value the flag register takes while reset is asserted.
  localparam fifo_flags_t FLAGS_RESET = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    half_flag:    1'b0
  };

endpackage

// File: rtl/fifo_flag_gen.sv
// Registered status-flag generator.
// The flags are computed from the occupancy the FIFO will hold after the
// current edge, so they change on the same edge as the count register.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_next_count   : occupancy after this edge, 0..2**ADDR_W
//   i_ae_thresh    : almost-empty threshold (count <= thresh)
//   i_af_thresh    : almost-full threshold  (count >= thresh)
//   o_flags        : registered flag bundle
module fifo_flag_gen
  import fifo_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   i_next_count,
  input  logic [ADDR_W:0]   i_ae_thresh,
  input  logic [ADDR_W:0]   i_af_thresh,
  output fifo_flags_t       o_flags
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_HALF  = (ADDR_W + 1)'(DEPTH / 2);

  fifo_flags_t w_flags_next;
  fifo_flags_t r_flags;

  // Thresholds are used as presented each cycle, so a threshold change is
  // visible on the flags at the next edge even if the count does not move.
  always_comb begin
    w_flags_next              = FLAGS_RESET;
    w_flags_next.full         = (i_next_count == CNT_FULL);
    w_flags_next.empty        = (i_next_count == '0);
    w_flags_next.half_flag    = (i_next_count >= CNT_HALF);
    w_flags_next.almost_empty = (i_next_count <= i_ae_thresh);
    w_flags_next.almost_full  = (i_next_count >= i_af_thresh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= FLAGS_RESET;
    end else begin
      r_flags <= w_flags_next;
    end
  end

  assign o_flags = r_flags;

endmodule

// File: rtl/param_fifo_flags.sv
// Synchronous FIFO with registered read data, occupancy count, programmable
// almost-empty/almost-full flags and sticky overflow/underflow errors.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_en, wr_data      : write request and word
//   rd_en               : read request
//   rd_data, rd_valid   : registered read word, one-cycle valid pulse
//   ae_thresh, af_thresh: almost-empty / almost-full occupancy thresholds
//   err_clr             : clears overflow/underflow
//   count               : occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty, half_flag : registered flags
//   overflow, underflow : sticky error flags
//
// Handshake: there is no backpressure signal. A read is accepted when
// rd_en is high and the FIFO is not empty; its word appears on rd_data with
// rd_valid high exactly one cycle later. A write is accepted when wr_en is
// high and the FIFO is not full, or is full but a read is accepted in the
// same cycle. Rejected requests are dropped and raise the matching sticky
// error flag.
module param_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic [ADDR_W:0]   ae_thresh,
  input  logic [ADDR_W:0]   af_thresh,
  input  logic              err_clr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              half_flag,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_underflow;

  fifo_flags_t       w_flags;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [ADDR_W:0]   w_next_count;

  // When full the FIFO is never empty, so a simultaneous read is always
  // accepted and frees the slot the write needs.
  assign w_rd_acc = rd_en && !w_flags.empty;
  assign w_wr_acc = wr_en && (!w_flags.full || w_rd_acc);

  always_comb begin
    w_next_count = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_next_count = r_count + (ADDR_W + 1)'(1);
      2'b01:   w_next_count = r_count - (ADDR_W + 1)'(1);
      default: w_next_count = r_count;
    endcase
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count    <= w_next_count;
      r_rd_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      // A new error wins over a coincident clear.
      r_overflow  <= (r_overflow && !err_clr) || (wr_en && !w_wr_acc);
      r_underflow <= (r_underflow && !err_clr) || (rd_en && !w_rd_acc);
    end
  end

  fifo_flag_gen #(
    .ADDR_W (ADDR_W)
  ) u_flag_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_next_count (w_next_count),
    .i_ae_thresh  (ae_thresh),
    .i_af_thresh  (af_thresh),
    .o_flags      (w_flags)
  );

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign full         = w_flags.full;
  assign empty        = w_flags.empty;
  assign almost_full  = w_flags.almost_full;
  assign almost_empty = w_flags.almost_empty;
  assign half_flag    = w_flags.half_flag;

endmodule

// File: tb/tb_param_fifo_flags.sv
// Bench for param_fifo_flags with default parameters (8-bit data, 256 deep).
// The reference model is a queue of stored words plus sticky error bits;
// flags are derived from the queue size with plain comparisons.
module tb_param_fifo_flags;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW:0]   ae_thresh;
  logic [AW:0]   af_thresh;
  logic          err_clr;
  logic [AW:0]   count;
  logic          full, empty, almost_full, almost_empty, half_flag;
  logic          overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard / reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rd_data;
  logic          exp_rd_valid;
  logic          exp_ovf;
  logic          exp_unf;

  param_fifo_flags #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .ae_thresh    (ae_thresh),
    .af_thresh    (af_thresh),
    .err_clr      (err_clr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .half_flag    (half_flag),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    exp_q.delete();
    exp_rd_data  = '0;
    exp_rd_valid = 1'b0;
    exp_ovf      = 1'b0;
    exp_unf      = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of requests (inputs change 1 time unit after an edge),
  // advances the model across the edge, and returns 1 unit after it.
  task automatic drive(input logic wr, input logic [DW-1:0] d,
                       input logic rd, input logic clr);
    int n;
    bit ra;
    bit wa;
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    err_clr = clr;
    n  = exp_q.size();
    ra = rd && (n > 0);
    wa = wr && ((n < DEPTH) || ra);
    @(posedge clk);
    exp_rd_valid = ra;
    if (ra) exp_rd_data = exp_q.pop_front();
    if (wa) exp_q.push_back(d);
    exp_ovf = (exp_ovf && !clr) || (wr && !wa);
    exp_unf = (exp_unf && !clr) || (rd && !ra);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; wr_en = 0; rd_en = 0; err_clr = 0; wr_data = '0;
    ae_thresh = 9'd8; af_thresh = 9'd248;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({full, empty, almost_full, almost_empty, half_flag} !== 5'b01010) begin
      $display("FAIL reset_flags_in_reset: got %b exp 01010",
               {full, empty, almost_full, almost_empty, half_flag}); n_fail++;
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (count !== 9'd0) begin
      $display("FAIL reset_count: got %0d exp 0", count); n_fail++;
    end
    n_tests++;
    if ({full, empty, almost_full, almost_empty, half_flag} !== 5'b01010) begin
      $display("FAIL reset_flags_idle: got %b exp 01010",
               {full, empty, almost_full, almost_empty, half_flag}); n_fail++;
    end
    n_tests++;
    if ({overflow, underflow, rd_valid} !== 3'b000 || rd_data !== 8'h00) begin
      $display("FAIL reset_err_rd: got ovf%b unf%b v%b d%0h exp 0 0 0 0",
               overflow, underflow, rd_valid, rd_data); n_fail++;
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      n_tests++;
      if (count !== 9'(i + 1) || almost_empty !== ((i + 1) <= 8) ||
          half_flag !== ((i + 1) >= 128) || almost_full !== ((i + 1) >= 248) ||
          full !== ((i + 1) == 256) || empty !== 1'b0) begin
        $display("FAIL fill_step%0d: got cnt%0d ae%b hf%b af%b f%b e%b exp cnt%0d ae%b hf%b af%b f%b e0",
                 i, count, almost_empty, half_flag, almost_full, full, empty,
                 i + 1, (i + 1) <= 8, (i + 1) >= 128, (i + 1) >= 248, (i + 1) == 256);
        n_fail++;
      end
    end
  endtask

  task automatic test_overflow_drain();
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    n_tests++;
    if (overflow !== 1'b1 || count !== 9'd256 || full !== 1'b1) begin
      $display("FAIL overflow_set: got ovf%b cnt%0d f%b exp ovf1 cnt256 f1",
               overflow, count, full); n_fail++;
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_tests++;
    if (overflow !== 1'b0) begin
      $display("FAIL overflow_clr: got %b exp 0", overflow); n_fail++;
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      n_tests++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i) || count !== 9'(DEPTH - 1 - i)) begin
        $display("FAIL drain_rd%0d: got v%b d%0h cnt%0d exp v1 d%0h cnt%0d",
                 i, rd_valid, rd_data, count, 8'(i), DEPTH - 1 - i); n_fail++;
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_tests++;
    if (empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'hFF || underflow !== 1'b0) begin
      $display("FAIL drain_end: got e%b v%b d%0h unf%b exp e1 v0 dff unf0",
               empty, rd_valid, rd_data, underflow); n_fail++;
    end
  endtask

  task automatic test_empty_rw();
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    n_tests++;
    if (underflow !== 1'b1 || count !== 9'd1 || rd_valid !== 1'b0) begin
      $display("FAIL empty_rw: got unf%b cnt%0d v%b exp unf1 cnt1 v0",
               underflow, count, rd_valid); n_fail++;
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || empty !== 1'b1) begin
      $display("FAIL empty_rw_read: got v%b d%0h e%b exp v1 da5 e1",
               rd_valid, rd_data, empty); n_fail++;
    end
    // Clear coinciding with a fresh underflow keeps the flag set.
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    n_tests++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'hA5) begin
      $display("FAIL clr_vs_new_err: got unf%b v%b d%0h exp unf1 v0 da5",
               underflow, rd_valid, rd_data); n_fail++;
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_tests++;
    if (underflow !== 1'b0) begin
      $display("FAIL underflow_clr: got %b exp 0", underflow); n_fail++;
    end
  endtask

  task automatic test_full_rw();
    logic [DW-1:0] front;
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    front = exp_q[0];
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    n_tests++;
    if (count !== 9'd256 || full !== 1'b1 || overflow !== 1'b0 ||
        rd_valid !== 1'b1 || rd_data !== front) begin
      $display("FAIL full_rw: got cnt%0d f%b ovf%b v%b d%0h exp cnt256 f1 ovf0 v1 d%0h",
               count, full, overflow, rd_valid, rd_data, front); n_fail++;
    end
    while (exp_q.size() > 0) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      n_tests++;
      if (rd_valid !== 1'b1 || rd_data !== exp_rd_data) begin
        $display("FAIL full_rw_drain: got v%b d%0h exp v1 d%0h",
                 rd_valid, rd_data, exp_rd_data); n_fail++;
      end
    end
    n_tests++;
    if (exp_q.size() > 0 && rd_data !== 8'h5A) begin
      $display("FAIL full_rw_last: got %0h exp 5a", rd_data); n_fail++;
    end
    if (rd_data !== 8'h5A) begin
      $display("FAIL full_rw_last_word: got %0h exp 5a", rd_data); n_fail++;
    end
  endtask

  task automatic test_thresh();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    ae_thresh = 9'd4; af_thresh = 9'd6;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_tests++;
    if (almost_empty !== 1'b0 || almost_full !== 1'b0) begin
      $display("FAIL thresh_a: got ae%b af%b exp ae0 af0", almost_empty, almost_full); n_fail++;
    end
    ae_thresh = 9'd5; af_thresh = 9'd5;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_tests++;
    if (almost_empty !== 1'b1 || almost_full !== 1'b1 || count !== 9'd5) begin
      $display("FAIL thresh_b: got ae%b af%b cnt%0d exp ae1 af1 cnt5",
               almost_empty, almost_full, count); n_fail++;
    end
    ae_thresh = 9'd8; af_thresh = 9'd248;
    while (exp_q.size() > 0) drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    int errs = 0;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
      n_tests++;
      if (rd_valid !== 1'b1 || rd_data !== exp_rd_data || count !== 9'd4 ||
          overflow !== 1'b0 || underflow !== 1'b0) begin
        $display("FAIL wrap_step%0d: got v%b d%0h cnt%0d ovf%b unf%b exp v1 d%0h cnt4 ovf0 unf0",
                 i, rd_valid, rd_data, count, overflow, underflow, exp_rd_data);
        n_fail++;
        errs++;
      end
    end
    while (exp_q.size() > 0) drive(1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++;
    if (rd_data !== exp_rd_data || empty !== 1'b1) begin
      $display("FAIL wrap_tail: got d%0h e%b exp d%0h e1", rd_data, empty, exp_rd_data); n_fail++;
    end
  endtask

  task automatic test_random();
    logic wr, rd, clr;
    int bias;
    for (int i = 0; i < 1500; i++) begin
      bias = (i / 250) % 2;  // alternate fill-leaning and drain-leaning phases
      wr  = ($urandom_range(0, 99) < (bias ? 75 : 35));
      rd  = ($urandom_range(0, 99) < (bias ? 35 : 75));
      clr = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 31) == 0) begin
        ae_thresh = 9'($urandom_range(0, 256));
        af_thresh = 9'($urandom_range(0, 256));
      end
      drive(wr, 8'($urandom), rd, clr);
      n_tests++;
      if (count !== 9'(exp_q.size()) || empty !== (exp_q.size() == 0) ||
          full !== (exp_q.size() == DEPTH) || half_flag !== (exp_q.size() >= DEPTH / 2) ||
          almost_empty !== (exp_q.size() <= int'(ae_thresh)) ||
          almost_full !== (exp_q.size() >= int'(af_thresh)) ||
          rd_valid !== exp_rd_valid || rd_data !== exp_rd_data ||
          overflow !== exp_ovf || underflow !== exp_unf) begin
        $display("FAIL random_step%0d: got cnt%0d e%b f%b hf%b ae%b af%b v%b d%0h ovf%b unf%b exp cnt%0d v%b d%0h ovf%b unf%b",
                 i, count, empty, full, half_flag, almost_empty, almost_full,
                 rd_valid, rd_data, overflow, underflow,
                 exp_q.size(), exp_rd_valid, exp_rd_data, exp_ovf, exp_unf);
        n_fail++;
      end
    end
    ae_thresh = 9'd8; af_thresh = 9'd248;
  endtask

  task automatic test_reset_mid();
    while (exp_q.size() > 0) drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) drive(1'b1, 8'(i + 7), 1'b0, 1'b0);
    n_tests++;
    if (count !== 9'd100) begin
      $display("FAIL mid_reset_pre: got cnt%0d exp 100", count); n_fail++;
    end
    #2 rst_n = 1'b0;   // mid-cycle, away from any edge
    #1;
    model_reset();
    n_tests++;
    if (count !== 9'd0 || {full, empty, almost_full, almost_empty, half_flag} !== 5'b01010 ||
        {overflow, underflow, rd_valid} !== 3'b000 || rd_data !== 8'h00) begin
      $display("FAIL mid_reset_async: got cnt%0d flags%b ovf%b unf%b v%b d%0h exp cnt0 flags01010 0 0 0 d0",
               count, {full, empty, almost_full, almost_empty, half_flag},
               overflow, underflow, rd_valid, rd_data); n_fail++;
    end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C || empty !== 1'b1 || dut.r_rd_ptr !== 8'd1) begin
      $display("FAIL mid_reset_post: got v%b d%0h e%b rptr%0d exp v1 d3c e1 rptr1",
               rd_valid, rd_data, empty, dut.r_rd_ptr); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_empty_rw();
    test_full_rw();
    test_thresh();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
